code25_serial_capture: RTL and testbench
========================================

// Module: code25_serial_capture
// PURPOSE
//  Serial front end for the 2-of-5 display path. Shifts in a 5-bit 2-of-5 codeword one bit per strobe.
//  Validates it (exactly two ones) and holds the last valid word on E1..E5 for the segment decoders.
//  Sits directly upstream of the per-segment combinational decoders (A..G).
// PARAMETERS
//  TIMEOUT_CYC  1000  max clk cycles between accepted bits inside a frame before the frame is aborted (>=2)
// PORTS
//  clk         in   1   single system clock, rising edge
//  rst_n       in   1   reset, asynchronous assert, active-low
//  frame_start in   1   1-cycle pulse: next accepted bit is E1 (first bit of frame)
//  bit_valid   in   1   strobe: bit_in is sampled on this clk edge
//  bit_in      in   1   serial data bit, order E1,E2,E3,E4,E5
//  E1..E5      out  1   held codeword to segment decoders (E1 = first bit received)
//  code_valid  out  1   1-cycle pulse: E1..E5 just updated with a valid word
//  code_err    out  1   1-cycle pulse: frame rejected (popcount!=2 or timeout)
//  busy        out  1   high while a frame is in progress (state SHIFT)
//  err_count   out  8   [CODE25_ERR_CNT_EN only] saturating count of code_err pulses
// BEHAVIOUR
//  Reset (rst_n=0, async): E1..E5=0, code_valid=0, code_err=0, busy=0, bit counter=0, timer=0, state IDLE.
//  FSM states: IDLE, SHIFT, CHECK.
//   IDLE : bit_valid ignored. frame_start -> SHIFT, cnt=0, timer=0, shift reg cleared.
//          If bit_valid is high in the same cycle as frame_start, that bit is accepted as E1.
//   SHIFT: each bit_valid shifts bit_in into sr[cnt], cnt++ (0..4), timer=0.
//          No bit_valid: timer++. Accepting the 5th bit (cnt==4) -> CHECK.
//          timer reaching TIMEOUT_CYC-1 with no bit -> pulse code_err, -> IDLE, outputs held.
//          frame_start in SHIFT: discard partial frame, no err pulse, restart (cnt=0, timer=0).
//          frame_start and bit_valid together: restart, and that bit is accepted as the new E1.
//   CHECK: one cycle. popcount(sr)==2 -> E1..E5<=sr, code_valid=1 for this one cycle.
//          Otherwise code_err=1 for this one cycle and E1..E5 keep the previous value.
//          Always -> IDLE. frame_start in CHECK is ignored.
//  Latency: code_valid/code_err are asserted 1 cycle after the 5th bit is accepted.
//   E1..E5 change in the same cycle code_valid is asserted.
//  code_valid and code_err are never both high. busy=1 exactly in SHIFT.
//  Timer width: $clog2(TIMEOUT_CYC); it saturates and never wraps.
//  Reset mid-frame: partial frame lost, no pulse, E1..E5 return to 0 (all segments blank).
// CONFIGURATION
//  `define CODE25_ERR_CNT_EN: adds port err_count[7:0], reset 0.
//   Increments on every code_err pulse and saturates at 255.
//  Without the macro: port absent, no counter logic. All other behaviour is identical.
// STRUCTURE
//  Shared header code25_defs.vh:
//   CODE25_W=5
//   FSM state localparams (IDLE=2'd0, SHIFT=2'd1, CHECK=2'd2)
//   list of the ten valid codewords, for the bench
//  Sub-module code25_checker: combinational, in [4:0] code -> out ok = (popcount==2).
//   Reusable by the decoder side.
// TESTING
//  1 frame_start, bits 0,1,0,0,1 -> one cycle later E1..E5=01001, code_valid=1 for 1 cycle, busy=0.
//  2 valid 01001 then frame 0,1,1,0,1 -> code_err=1 for 1 cycle, E1..E5 stay 01001;
//    with macro, err_count=1.
//  3 bits 1,1,0 then frame_start, then 1,0,0,0,1 -> no err pulse, E1..E5=10001, code_valid=1.
//  4 frame_start, 2 bits, then TIMEOUT_CYC idle cycles -> code_err=1 once, state IDLE, busy=0.
//  5 bit_valid pulses in IDLE -> no change. rst_n=0 after 3 bits -> all outputs 0 immediately (async).
//  6 all 32 5-bit words -> code_valid only for the 10 words with two ones.
//    With macro, 256+ bad frames -> err_count holds at 255.

Source files
------------

// File: rtl/code25_serial_capture_pkg.sv
// rtl/code25_serial_capture_pkg.sv - shared widths, FSM states and valid codewords for the 2-of-5 capture path
package code25_serial_capture_pkg;

  localparam int CODE25_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    CHECK = 2'd2
  } state_t;

  // The ten words with exactly two ones, written E1..E5 left to right.
  localparam logic [CODE25_W-1:0] VALID_CODES [10] = '{
    5'b11000, 5'b10100, 5'b10010, 5'b10001, 5'b01100,
    5'b01010, 5'b01001, 5'b00110, 5'b00101, 5'b00011
  };

endpackage

// File: rtl/code25_checker.sv
// rtl/code25_checker.sv - combinational 2-of-5 validity check, shared with the decoder side
module code25_checker
  import code25_serial_capture_pkg::*;
(
  input  logic [CODE25_W-1:0] code,
  output logic                ok
);

  assign ok = ($countones(code) == 2);

endmodule

// File: rtl/code25_serial_capture.sv
// rtl/code25_serial_capture.sv - serial 2-of-5 codeword capture; `CODE25_ERR_CNT_EN adds err_count
module code25_serial_capture
  import code25_serial_capture_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_start,
  input  logic       bit_valid,
  input  logic       bit_in,
  output logic       E1,
  output logic       E2,
  output logic       E3,
  output logic       E4,
  output logic       E5,
  output logic       code_valid,
  output logic       code_err,
  output logic       busy
`ifdef CODE25_ERR_CNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam int TW = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);

  state_t              state;
  logic [CODE25_W-1:0] sr;
  logic [CODE25_W-1:0] code_q;
  logic [2:0]          cnt;
  logic [TW-1:0]       timer;
  logic                sr_ok;
  logic                err_fire;

  code25_checker u_checker (
    .code (sr),
    .ok   (sr_ok)
  );

  // sr[0] holds the first received bit, so it drives E1.
  assign {E5, E4, E3, E2, E1} = code_q;

  assign err_fire = ((state == CHECK) && !sr_ok) ||
                    ((state == SHIFT) && !frame_start && !bit_valid && (timer == T_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      code_q     <= '0;
      cnt        <= '0;
      timer      <= '0;
      code_valid <= 1'b0;
      code_err   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      code_err   <= err_fire;
      if ((state == IDLE || state == SHIFT) && frame_start) begin
        // Start or restart: a coincident strobe is the new E1.
        state <= SHIFT;
        busy  <= 1'b1;
        timer <= '0;
        if (bit_valid) begin
          sr  <= {{(CODE25_W-1){1'b0}}, bit_in};
          cnt <= 3'd1;
        end else begin
          sr  <= '0;
          cnt <= 3'd0;
        end
      end else begin
        unique case (state)
          IDLE: ;
          SHIFT: begin
            if (bit_valid) begin
              sr[cnt] <= bit_in;
              timer   <= '0;
              if (cnt == 3'd4) begin
                state <= CHECK;
                busy  <= 1'b0;
                cnt   <= 3'd0;
              end else begin
                cnt <= cnt + 3'd1;
              end
            end else if (timer == T_LAST) begin
              state <= IDLE;
              busy  <= 1'b0;
              cnt   <= 3'd0;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          CHECK: begin
            if (sr_ok) begin
              code_q     <= sr;
              code_valid <= 1'b1;
            end
            state <= IDLE;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef CODE25_ERR_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= 8'd0;
    end else if (err_fire && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_code25_serial_capture.sv
// tb/tb_code25_serial_capture.sv - randomized bench for code25_serial_capture against a frame-level model
module tb_code25_serial_capture;

  localparam int TO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic frame_start = 1'b0;
  logic bit_valid = 1'b0;
  logic bit_in = 1'b0;
  logic E1, E2, E3, E4, E5;
  logic code_valid, code_err, busy;
`ifdef CODE25_ERR_CNT_EN
  logic [7:0] err_count;
`endif

  code25_serial_capture #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .bit_valid   (bit_valid),
    .bit_in      (bit_in),
    .E1          (E1),
    .E2          (E2),
    .E3          (E3),
    .E4          (E4),
    .E5          (E5),
    .code_valid  (code_valid),
    .code_err    (code_err),
    .busy        (busy)
`ifdef CODE25_ERR_CNT_EN
    ,
    .err_count   (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int n_valid_seen = 0;
  int n_err_seen   = 0;

  // Frame-level reference: collected bits, idle gap since last bit.
  bit         m_bits[$];
  int         m_gap;
  bit         m_in_frame;
  bit         m_pending;
  logic [4:0] m_word;
  bit         m_valid, m_err;
  int         m_ecnt;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [4:0] out_word();
    return {E1, E2, E3, E4, E5};
  endfunction

  task automatic model_reset();
    m_bits.delete();
    m_gap = 0; m_in_frame = 0; m_pending = 0;
    m_word = '0; m_valid = 0; m_err = 0; m_ecnt = 0;
  endtask

  task automatic model_step(input logic fs, input logic bv, input logic bi);
    int ones;
    logic [4:0] w;
    m_valid = 0;
    m_err   = 0;
    if (m_pending) begin
      m_pending = 0;
      ones = 0;
      w = '0;
      foreach (m_bits[i]) begin
        ones += m_bits[i];
        w = {w[3:0], m_bits[i]};
      end
      if (ones == 2) begin
        m_word  = w;
        m_valid = 1;
      end else begin
        m_err = 1;
      end
    end else if (fs) begin
      m_in_frame = 1;
      m_bits.delete();
      m_gap = 0;
      if (bv) m_bits.push_back(bi);
    end else if (m_in_frame) begin
      if (bv) begin
        m_bits.push_back(bi);
        m_gap = 0;
        if (m_bits.size() == 5) begin
          m_pending  = 1;
          m_in_frame = 0;
        end
      end else begin
        m_gap++;
        if (m_gap == TO) begin
          m_err      = 1;
          m_in_frame = 0;
        end
      end
    end
    if (m_err && m_ecnt < 255) m_ecnt++;
  endtask

  task automatic step(input logic fs, input logic bv, input logic bi);
    frame_start = fs;
    bit_valid   = bv;
    bit_in      = bi;
    @(posedge clk);
    model_step(fs, bv, bi);
    #1;
    check("cycle", {24'd0, out_word(), code_valid, code_err, busy},
          {24'd0, m_word, m_valid, m_err, m_in_frame});
`ifdef CODE25_ERR_CNT_EN
    check("err_count", {24'd0, err_count}, m_ecnt);
`endif
    if (code_valid) n_valid_seen++;
    if (code_err)   n_err_seen++;
  endtask

  task automatic send_frame(input logic [4:0] w);
    step(1'b1, 1'b1, w[4]);
    for (int i = 3; i >= 0; i--) step(1'b0, 1'b1, w[i]);
    step(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [4:0] wv;
    int ones_cnt;
    int exp_valid;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_outs", {out_word(), code_valid, code_err, busy}, 8'd0);
    rst_n = 1'b1;

    // Directed: valid word, bad word, restart mid-frame.
    send_frame(5'b01001);
    check("t1_word", out_word(), 5'b01001);
    check("t1_busy", busy, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    check("t1_pulse_one_cycle", code_valid, 1'b0);
    n_err_seen = 0;
    send_frame(5'b01101);
    check("t2_err", code_err, 1'b1);
    check("t2_word_held", out_word(), 5'b01001);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    send_frame(5'b10001);
    check("t3_no_err", n_err_seen, 1);
    check("t3_word", out_word(), 5'b10001);
    check("t3_valid", code_valid, 1'b1);

    // Timeout after two bits.
    n_err_seen = 0;
    step(1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < TO - 1; i++) step(1'b0, 1'b0, 1'b0);
    check("t4_busy_before", busy, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    check("t4_err", code_err, 1'b1);
    check("t4_busy_after", busy, 1'b0);
    repeat (3) step(1'b0, 1'b0, 1'b0);
    check("t4_err_once", n_err_seen, 1);

    // Strobes in IDLE are ignored, then async reset mid-frame.
    repeat (4) step(1'b0, 1'b1, 1'b1);
    check("t5_idle_word", out_word(), 5'b10001);
    step(1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_async_reset", {out_word(), code_valid, code_err, busy}, 8'd0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // All 32 words.
    n_valid_seen = 0;
    exp_valid = 0;
    for (int w = 0; w < 32; w++) begin
      wv = 5'(w);
      ones_cnt = 0;
      for (int b = 0; b < 5; b++) ones_cnt += wv[b];
      if (ones_cnt == 2) exp_valid++;
      send_frame(wv);
    end
    check("t6_valid_words", n_valid_seen, exp_valid);
    check("t6_ten_valid", n_valid_seen, 10);

    // Random stimulus with varying strobe density so timeouts occur.
    for (int blk = 0; blk < 40; blk++) begin
      int dens;
      dens = $urandom_range(1, 40);
      for (int c = 0; c < 60; c++) begin
        step(($urandom_range(0, 24) == 0),
             ($urandom_range(0, dens) == 0),
             1'($urandom_range(0, 1)));
      end
    end

`ifdef CODE25_ERR_CNT_EN
    for (int f = 0; f < 260; f++) send_frame(5'b11111);
    check("t6_err_sat", err_count, 8'd255);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
